// File: rtl/btn_conditioner.sv
// Debounced button front end: 2-FF synchronizer and one debounce FSM per channel.
// Outputs are the clean level plus one-cycle press and release pulses.
// Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses while a button is held.
module btn_conditioner #(
    parameter int unsigned NUM_BTN              = 4,
    parameter logic [28:0] DEBOUNCE_CYCLES      = 29'd1_000_000,
    parameter logic [28:0] REPEAT_DELAY_CYCLES  = 29'd50_000_000,
    parameter logic [28:0] REPEAT_PERIOD_CYCLES = 29'd10_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } chanState_t;

    localparam logic [28:0] DEB_LAST = DEBOUNCE_CYCLES - 29'd1;

    // Reject configurations that would underflow the compare thresholds.
    if (DEBOUNCE_CYCLES < 29'd2 || REPEAT_DELAY_CYCLES == 29'd0 || REPEAT_PERIOD_CYCLES == 29'd0) begin : gParamCheck
        $error("btn_conditioner: invalid cycle parameters");
    end

    logic [NUM_BTN-1:0] syncMeta;
    logic [NUM_BTN-1:0] syncQ;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncMeta <= '0;
            syncQ    <= '0;
        end else begin
            syncMeta <= btn_raw;
            syncQ    <= syncMeta;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : gChan
        chanState_t  state, stateNext;
        logic [28:0] cnt, cntNext;
        logic        levelQ, levelNext;
        logic        pressQ, pressNext;
        logic        releaseQ, releaseNext;
        logic        repFire;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= IDLE_LO;
                cnt      <= '0;
                levelQ   <= 1'b0;
                pressQ   <= 1'b0;
                releaseQ <= 1'b0;
            end else begin
                state    <= stateNext;
                cnt      <= cntNext;
                levelQ   <= levelNext;
                pressQ   <= pressNext | repFire;
                releaseQ <= releaseNext;
            end
        end

        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        always_comb begin
            stateNext   = state;
            cntNext     = cnt;
            levelNext   = levelQ;
            pressNext   = 1'b0;
            releaseNext = 1'b0;
            unique case (state)
                IDLE_LO: begin
                    if (syncQ[i]) begin
                        stateNext = CHK_HI;
                        cntNext   = 29'd1;
                    end
                end
                CHK_HI: begin
                    if (!syncQ[i]) begin
                        stateNext = IDLE_LO;
                        cntNext   = '0;
                    end else if (cnt == DEB_LAST) begin
                        stateNext = IDLE_HI;
                        cntNext   = '0;
                        levelNext = 1'b1;
                        pressNext = 1'b1;
                    end else begin
                        cntNext = cnt + 29'd1;
                    end
                end
                IDLE_HI: begin
                    if (!syncQ[i]) begin
                        stateNext = CHK_LO;
                        cntNext   = 29'd1;
                    end
                end
                CHK_LO: begin
                    if (syncQ[i]) begin
                        stateNext = IDLE_HI;
                        cntNext   = '0;
                    end else if (cnt == DEB_LAST) begin
                        stateNext   = IDLE_LO;
                        cntNext     = '0;
                        levelNext   = 1'b0;
                        releaseNext = 1'b1;
                    end else begin
                        cntNext = cnt + 29'd1;
                    end
                end
                default: begin
                    stateNext = IDLE_LO;
                    cntNext   = '0;
                end
            endcase
        end

`ifdef BTN_AUTOREPEAT_EN
        localparam logic [28:0] DLY_LAST = REPEAT_DELAY_CYCLES - 29'd1;
        localparam logic [28:0] PER_LAST = REPEAT_PERIOD_CYCLES - 29'd1;

        logic [28:0] rep, repNext;
        logic        repeating, repeatingNext;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rep       <= '0;
                repeating <= 1'b0;
            end else begin
                rep       <= repNext;
                repeating <= repeatingNext;
            end
        end

        // Counts while held (IDLE_HI or CHK_LO); the accepting release edge never repeats.
        always_comb begin
            repNext       = rep;
            repeatingNext = repeating;
            repFire       = 1'b0;
            if (pressNext) begin
                repNext       = '0;
                repeatingNext = 1'b0;
            end else if ((state == IDLE_HI || state == CHK_LO) && !releaseNext) begin
                if (rep == (repeating ? PER_LAST : DLY_LAST)) begin
                    repFire       = 1'b1;
                    repNext       = '0;
                    repeatingNext = 1'b1;
                end else begin
                    repNext = rep + 29'd1;
                end
            end else begin
                repNext       = '0;
                repeatingNext = 1'b0;
            end
        end
`else
        assign repFire = 1'b0;
`endif

        assign btn_level[i]   = levelQ;
        assign btn_press[i]   = pressQ;
        assign btn_release[i] = releaseQ;
    end

endmodule
